// File: rtl/ws2812b_rx_decoder.sv
// WS2812B one-wire receiver: pulse-width bit decode into 24-bit GRB pixels.
// Optional cascade forwarding of pixels after the first: WS2812B_RX_FORWARD_EN.
module ws2812b_rx_decoder #(
  parameter int unsigned BIT_THRESHOLD = 7,
  parameter int unsigned HIGH_MAX      = 40,
  parameter int unsigned RESET_CYCLES  = 600
) (
  input  logic        clk_12mhz,
  input  logic        resetn,
  input  logic        din,
  output logic        pixel_valid,
  output logic [23:0] pixel_grb,
  output logic [7:0]  pixel_index,
  output logic        frame_start,
  output logic        frame_end,
  output logic        err,
  output logic        dout
);

  localparam logic [15:0] BIT_TH = 16'(BIT_THRESHOLD);
  localparam logic [15:0] HI_MAX = 16'(HIGH_MAX);
  localparam logic [15:0] RST_C  = 16'(RESET_CYCLES);

  typedef enum logic [1:0] {
    WAIT_LATCH,
    LOW,
    HIGH
  } state_t;

  state_t      state_q, state_d;
  logic        sync1_q;
  logic        din_s_q;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] cnt_inc;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [23:0] shift_q, shift_d;
  logic [7:0]  idx_q, idx_d;
  logic        active_q, active_d;
  logic        pixel_valid_q, pixel_valid_d;
  logic [23:0] pixel_grb_q, pixel_grb_d;
  logic [7:0]  pixel_index_q, pixel_index_d;
  logic        frame_start_q, frame_start_d;
  logic        frame_end_q, frame_end_d;
  logic        err_q, err_d;

  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_inc;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    idx_d         = idx_q;
    active_d      = active_q;
    pixel_valid_d = 1'b0;
    pixel_grb_d   = pixel_grb_q;
    pixel_index_d = pixel_index_q;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    err_d         = 1'b0;

    // a word completed on the previous edge is published now
    if (bit_cnt_q == 5'd24) begin
      pixel_valid_d = 1'b1;
      pixel_grb_d   = shift_q;
      pixel_index_d = idx_q;
      idx_d         = idx_q + 8'd1;
      bit_cnt_d     = 5'd0;
    end

    case (state_q)
      WAIT_LATCH: begin
        if (din_s_q) begin
          cnt_d = 16'd0;
        end else if (cnt_q == RST_C) begin
          state_d = LOW;
        end
      end
      LOW: begin
        if (din_s_q) begin
          state_d = HIGH;
          cnt_d   = 16'd1;
          if (!active_q) begin
            frame_start_d = 1'b1;
            active_d      = 1'b1;
          end
        end else if (cnt_q == RST_C && active_q) begin
          frame_end_d = 1'b1;
          err_d       = (bit_cnt_q != 5'd0);
          bit_cnt_d   = 5'd0;
          idx_d       = 8'd0;
          active_d    = 1'b0;
        end
      end
      HIGH: begin
        if (cnt_q >= HI_MAX) begin
          err_d     = 1'b1;
          bit_cnt_d = 5'd0;
          idx_d     = 8'd0;
          active_d  = 1'b0;
          cnt_d     = 16'd0;
          state_d   = WAIT_LATCH;
        end else if (!din_s_q) begin
          shift_d   = {shift_q[22:0], (cnt_q >= BIT_TH)};
          bit_cnt_d = bit_cnt_q + 5'd1;
          cnt_d     = 16'd1;
          state_d   = LOW;
        end
      end
      default: begin
        state_d = WAIT_LATCH;
        cnt_d   = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk_12mhz) begin
    if (!resetn) begin
      state_q       <= WAIT_LATCH;
      sync1_q       <= 1'b0;
      din_s_q       <= 1'b0;
      cnt_q         <= 16'd0;
      bit_cnt_q     <= 5'd0;
      shift_q       <= 24'd0;
      idx_q         <= 8'd0;
      active_q      <= 1'b0;
      pixel_valid_q <= 1'b0;
      pixel_grb_q   <= 24'd0;
      pixel_index_q <= 8'd0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= din;
      din_s_q       <= sync1_q;
      cnt_q         <= cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      idx_q         <= idx_d;
      active_q      <= active_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_grb_q   <= pixel_grb_d;
      pixel_index_q <= pixel_index_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      err_q         <= err_d;
    end
  end

  assign pixel_valid = pixel_valid_q;
  assign pixel_grb   = pixel_grb_q;
  assign pixel_index = pixel_index_q;
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;
  assign err         = err_q;

`ifdef WS2812B_RX_FORWARD_EN
  logic fwd_q, fwd_d;
  logic last_bit_px0;

  // 24th falling edge of pixel 0 opens the pass-through
  assign last_bit_px0 = (state_q == HIGH) && !din_s_q && (cnt_q < HI_MAX)
                     && (bit_cnt_q == 5'd23) && (idx_q == 8'd0);

  always_comb begin
    fwd_d = fwd_q;
    if (last_bit_px0) fwd_d = 1'b1;
    if (frame_end_d || err_d) fwd_d = 1'b0;
  end

  always_ff @(posedge clk_12mhz) begin
    if (!resetn) fwd_q <= 1'b0;
    else         fwd_q <= fwd_d;
  end

  assign dout = din_s_q & fwd_q;
`else
  assign dout = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812b_rx_decoder.sv
// Directed scoreboard bench for ws2812b_rx_decoder.
// Pixels are queued as they are sent and checked when pixel_valid fires.
module tb_ws2812b_rx_decoder;

  logic        clk_12mhz = 1'b0;
  logic        resetn = 1'b0;
  logic        din = 1'b0;
  logic        pixel_valid;
  logic [23:0] pixel_grb;
  logic [7:0]  pixel_index;
  logic        frame_start;
  logic        frame_end;
  logic        err;
  logic        dout;

  ws2812b_rx_decoder dut (
    .clk_12mhz  (clk_12mhz),
    .resetn     (resetn),
    .din        (din),
    .pixel_valid(pixel_valid),
    .pixel_grb  (pixel_grb),
    .pixel_index(pixel_index),
    .frame_start(frame_start),
    .frame_end  (frame_end),
    .err        (err),
    .dout       (dout)
  );

  always #5 clk_12mhz = ~clk_12mhz;

  typedef struct {
    logic [23:0] grb;
    logic [7:0]  idx;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_fall = 0;
  int n_fs = 0, n_fe = 0, n_err = 0, n_pv = 0, n_same = 0;
  int fe_lat = 0;
  int win = 0;
  int dout_bad = 0;
  logic h1 = 1'b0, h2 = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk_12mhz) begin
    cyc <= cyc + 1;
    h1  <= din;
    h2  <= h1;
  end

  always @(negedge clk_12mhz) begin
    if (resetn) begin
      if (frame_start) n_fs++;
      if (frame_end) begin
        n_fe++;
        fe_lat = cyc - last_fall;
      end
      if (err) n_err++;
      if (frame_end && err) n_same++;
      if (pixel_valid) begin
        n_pv++;
        if (sb.size() == 0) begin
          chk("unexpected_pixel", 64'(pixel_grb), 64'hFFFF_FFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("pixel_grb", 64'(pixel_grb), 64'(e.grb));
          chk("pixel_index", 64'(pixel_index), 64'(e.idx));
          chk("pixel_latency", 64'(cyc - last_fall), 64'd3);
        end
      end
      if (win == 1 && dout !== 1'b0) dout_bad++;
      if (win == 2 && dout !== h2) dout_bad++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_12mhz);
    #1;
  endtask

  task automatic send_raw(input int h, input int l);
    din = 1'b1;
    tick(h);
    din = 1'b0;
    last_fall = cyc + 1;
    tick(l);
  endtask

  task automatic send_bit(input logic b);
    if (b) send_raw(10, 5);
    else   send_raw(5, 10);
  endtask

  task automatic send_px(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic push(input logic [23:0] w, input logic [7:0] idx);
    exp_t e;
    e.grb = w;
    e.idx = idx;
    sb.push_back(e);
  endtask

  task automatic gap(input int n);
    din = 1'b0;
    tick(n);
  endtask

  task automatic clr();
    n_fs = 0; n_fe = 0; n_err = 0; n_pv = 0; n_same = 0;
  endtask

  initial begin
    logic [11:0] part;
    logic [23:0] bnd;
    part = 12'hABC;
    bnd  = 24'hAAAAAA;

    tick(5);
    chk("reset_outputs",
        {pixel_valid, frame_start, frame_end, err, dout, pixel_index, pixel_grb},
        64'd0);
    resetn = 1'b1;
    gap(650);
    clr();

    // single pixel
    push(24'h00FF00, 8'd0);
    send_px(24'h00FF00);
    gap(650);
    chk("t1_frame_start", 64'(n_fs), 64'd1);
    chk("t1_pixels", 64'(n_pv), 64'd1);
    chk("t1_frame_end", 64'(n_fe), 64'd1);
    chk("t1_err", 64'(n_err), 64'd0);
    clr();

    // three pixels, frame_end latency
    push(24'h123456, 8'd0);
    push(24'hABCDEF, 8'd1);
    push(24'h000001, 8'd2);
    send_px(24'h123456);
    send_px(24'hABCDEF);
    send_px(24'h000001);
    gap(650);
    chk("t2_pixels", 64'(n_pv), 64'd3);
    chk("t2_frame_end", 64'(n_fe), 64'd1);
    chk("t2_fe_latency", 64'(fe_lat), 64'd602);
    chk("t2_hold_index", 64'(pixel_index), 64'd2);
    chk("t2_hold_grb", 64'(pixel_grb), 64'h000001);
    clr();

    // partial pixel at the latch
    for (int i = 11; i >= 0; i--) send_bit(part[i]);
    gap(650);
    chk("t3_err", 64'(n_err), 64'd1);
    chk("t3_frame_end", 64'(n_fe), 64'd1);
    chk("t3_same_cycle", 64'(n_same), 64'd1);
    chk("t3_no_pixel", 64'(n_pv), 64'd0);
    clr();
    push(24'hFFFFFF, 8'd0);
    send_px(24'hFFFFFF);
    gap(650);
    chk("t3_next_pixels", 64'(n_pv), 64'd1);
    chk("t3_next_err", 64'(n_err), 64'd0);
    clr();

    // stuck high, then an ungapped pixel is ignored
    din = 1'b1;
    tick(40);
    din = 1'b0;
    tick(20);
    chk("t4_stuck_err", 64'(n_err), 64'd1);
    chk("t4_stuck_no_fe", 64'(n_fe), 64'd0);
    clr();
    send_px(24'h0000FF);
    gap(650);
    chk("t4_ignored", 64'(n_pv), 64'd0);
    chk("t4_ignored_fe", 64'(n_fe), 64'd0);
    push(24'h0000FF, 8'd0);
    send_px(24'h0000FF);
    gap(650);
    chk("t4_pixels", 64'(n_pv), 64'd1);
    chk("t4_frame_end", 64'(n_fe), 64'd1);
    clr();

    // reset in mid-pixel
    push(24'h5A5A5A, 8'd0);
    push(24'hC3C3C3, 8'd1);
    send_px(24'h5A5A5A);
    send_px(24'hC3C3C3);
    for (int i = 0; i < 10; i++) send_bit(i[0]);
    chk("t5_pre_index", 64'(pixel_index), 64'd1);
    resetn = 1'b0;
    tick(1);
    chk("t5_reset_outputs",
        {pixel_valid, frame_start, frame_end, err, dout, pixel_index, pixel_grb},
        64'd0);
    resetn = 1'b1;
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    gap(650);
    chk("t5_pixels", 64'(n_pv), 64'd2);
    chk("t5_no_fe", 64'(n_fe), 64'd0);
    chk("t5_no_err", 64'(n_err), 64'd0);
    clr();
    push(24'h800000, 8'd0);
    send_px(24'h800000);
    gap(650);
    chk("t5_after_pixels", 64'(n_pv), 64'd1);
    chk("t5_after_fe", 64'(n_fe), 64'd1);
    clr();

    // forwarding
    push(24'h0F0F0F, 8'd0);
    push(24'h5AC3E1, 8'd1);
    dout_bad = 0;
    win = 1;
    send_px(24'h0F0F0F);
    win = 0;
    chk("t6_dout_px0", 64'(dout_bad), 64'd0);
    dout_bad = 0;
`ifdef WS2812B_RX_FORWARD_EN
    win = 2;
`else
    win = 1;
`endif
    send_px(24'h5AC3E1);
    win = 0;
    chk("t6_dout_px1", 64'(dout_bad), 64'd0);
    gap(650);
    chk("t6_frame_end", 64'(n_fe), 64'd1);
    dout_bad = 0;
    win = 1;
    tick(20);
    win = 0;
    chk("t6_dout_after", 64'(dout_bad), 64'd0);
    clr();

    // threshold and stuck-high boundaries
    push(bnd, 8'd0);
    send_raw(39, 8);
    for (int i = 22; i >= 0; i--) begin
      if (bnd[i]) send_raw(7, 8);
      else        send_raw(6, 9);
    end
    gap(650);
    chk("t7_pixels", 64'(n_pv), 64'd1);
    chk("t7_no_err", 64'(n_err), 64'd0);
    chk("t7_frame_end", 64'(n_fe), 64'd1);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
